// File: rtl/macro_mux_sync_nch_if.sv
// rtl/macro_mux_sync_nch_if.sv - merged valid/ready stream carrying channel-tagged words
interface macro_mux_sync_nch_if #(
  parameter int WIDTH = 8,
  parameter int CHW   = 2
);
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [CHW-1:0]   m_ch;

  modport master (output m_valid, output m_data, output m_ch, input m_ready);
  modport slave  (input m_valid, input m_data, input m_ch, output m_ready);
endinterface

// File: rtl/macro_mux_sync_nch.sv
// rtl/macro_mux_sync_nch.sv - multi-channel req-synchronised data capture with round-robin merge
module macro_mux_sync_nch #(
  parameter int NCH         = 4,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 1,
  parameter int CHW         = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NCH-1:0]       req,
  input  logic [NCH*WIDTH-1:0] data,
  input  logic [NCH-1:0]       ovf_clr,
  output logic [NCH*WIDTH-1:0] data_sync,
  output logic [NCH-1:0]       vld,
  output logic [NCH-1:0]       ack,
  output logic [NCH-1:0]       ovf,
  macro_mux_sync_nch_if.master m
);

  logic [NCH-1:0]   sync_q [SYNC_STAGES];
  logic [NCH-1:0]   rs;
  logic [NCH-1:0]   p_q;
  logic [NCH-1:0]   ld;
  logic [WIDTH-1:0] ds_q [NCH];
  logic [NCH-1:0]   vld_q;
  logic [NCH-1:0]   pend_q;
  logic [NCH-1:0]   ovf_q;
  logic             mv_q;
  logic [WIDTH-1:0] md_q;
  logic [CHW-1:0]   mc_q;
  logic [CHW-1:0]   ptr_q;

  logic             gnt_found;
  logic [CHW-1:0]   gnt_idx;
  logic             load_en;
  logic             gnt;
  logic [NCH-1:0]   gnt_vec;
  int               idx;

  assign rs = sync_q[SYNC_STAGES-1];
  assign ld = (MODE == 1) ? (rs ^ p_q) : rs;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      p_q <= '0;
    end else begin
      sync_q[0] <= req;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      p_q <= rs;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < NCH; c++) ds_q[c] <= '0;
      vld_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++)
        if (ld[c]) ds_q[c] <= data[c*WIDTH +: WIDTH];
      vld_q <= ld;
    end
  end

  // Search starts one past the last grant so every pending channel is served within NCH words.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(ptr_q) + i) % NCH;
      if (!gnt_found && pend_q[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = CHW'(idx);
      end
    end
    load_en = !mv_q || m.m_ready;
    gnt     = load_en && gnt_found && (MODE == 1);
    gnt_vec = '0;
    if (gnt) gnt_vec[gnt_idx] = 1'b1;
  end

  // A capture coinciding with a grant keeps pending set: the granted word is the old one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q <= '0;
      ovf_q  <= '0;
      mv_q   <= 1'b0;
      md_q   <= '0;
      mc_q   <= '0;
      ptr_q  <= CHW'(NCH - 1);
    end else begin
      if (MODE == 1) begin
        pend_q <= (pend_q & ~gnt_vec) | ld;
        ovf_q  <= (ovf_q & ~ovf_clr) | (ld & pend_q & ~gnt_vec);
      end else begin
        pend_q <= '0;
        ovf_q  <= '0;
      end
      if (gnt) begin
        md_q  <= ds_q[gnt_idx];
        mc_q  <= gnt_idx;
        mv_q  <= 1'b1;
        ptr_q <= gnt_idx;
      end else if (m.m_ready) begin
        mv_q <= 1'b0;
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_pack
    assign data_sync[c*WIDTH +: WIDTH] = ds_q[c];
  end

  assign vld       = vld_q;
  assign ack       = p_q;
  assign ovf       = ovf_q;
  assign m.m_valid = mv_q;
  assign m.m_data  = md_q;
  assign m.m_ch    = mc_q;

endmodule

// File: tb/tb_macro_mux_sync_nch.sv
// tb/tb_macro_mux_sync_nch.sv - scoreboard bench for toggle-mode and level-mode instances
module tb_macro_mux_sync_nch;
  localparam int NCH = 4, WIDTH = 8, CHW = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]       req, ovf_clr, vld, ack, ovf;
  logic [NCH*WIDTH-1:0] data, data_sync;
  logic [NCH-1:0]       req0, ovf_clr0, vld0, ack0, ovf0;
  logic [NCH*WIDTH-1:0] data0, data_sync0;

  macro_mux_sync_nch_if #(.WIDTH(WIDTH), .CHW(CHW)) mif ();
  macro_mux_sync_nch_if #(.WIDTH(WIDTH), .CHW(CHW)) mif0 ();

  macro_mux_sync_nch #(.NCH(NCH), .WIDTH(WIDTH), .SYNC_STAGES(2), .MODE(1), .CHW(CHW)) dut (
    .clk(clk), .rstn(rstn), .req(req), .data(data), .ovf_clr(ovf_clr),
    .data_sync(data_sync), .vld(vld), .ack(ack), .ovf(ovf), .m(mif.master)
  );

  macro_mux_sync_nch #(.NCH(NCH), .WIDTH(WIDTH), .SYNC_STAGES(2), .MODE(0), .CHW(CHW)) dut0 (
    .clk(clk), .rstn(rstn), .req(req0), .data(data0), .ovf_clr(ovf_clr0),
    .data_sync(data_sync0), .vld(vld0), .ack(ack0), .ovf(ovf0), .m(mif0.master)
  );

  typedef struct packed {
    logic [CHW-1:0]   ch;
    logic [WIDTH-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic [WIDTH-1:0] d);
    exp_t e;
    e.ch = CHW'(ch);
    e.d  = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req = '0; data = '0; ovf_clr = '0; mif.m_ready = 1'b0;
    req0 = '0; data0 = '0; ovf_clr0 = '0; mif0.m_ready = 1'b0;
    sb.delete();
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req = '0; data = '0; ovf_clr = '0; mif.m_ready = 1'b0;
    req0 = '0; data0 = '0; ovf_clr0 = '0; mif0.m_ready = 1'b0;
    tick();
    checks++;
    if ({vld, ack, ovf, data_sync, mif.m_valid, mif.m_data, mif.m_ch} !== '0) begin
      errors++;
      $display("FAIL reset_mode1: got vld=%b ack=%b ovf=%b ds=%h mv=%b md=%h mc=%0d want all 0",
               vld, ack, ovf, data_sync, mif.m_valid, mif.m_data, mif.m_ch);
    end
    checks++;
    if ({vld0, ack0, ovf0, data_sync0, mif0.m_valid, mif0.m_data, mif0.m_ch} !== '0) begin
      errors++;
      $display("FAIL reset_mode0: got vld=%b ack=%b ds=%h mv=%b want all 0",
               vld0, ack0, data_sync0, mif0.m_valid);
    end
  endtask

  task automatic test_single_toggle();
    exp_t e;
    do_reset();
    mif.m_ready = 1'b1;
    req[0] = 1'b1;
    data[7:0] = 8'hA5;
    push(0, 8'hA5);
    tick();
    tick();
    checks++;
    if (vld !== '0) begin
      errors++;
      $display("FAIL single_early_vld: got %b want 0000", vld);
    end
    tick();
    checks++;
    if (vld !== 4'b0001 || data_sync[7:0] !== 8'hA5 || ack[0] !== 1'b1 || mif.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_edge3: got vld=%b ds0=%h ack0=%b mv=%b want vld=0001 ds0=a5 ack0=1 mv=0",
               vld, data_sync[7:0], ack[0], mif.m_valid);
    end
    tick();
    checks++;
    if (vld !== '0) begin
      errors++;
      $display("FAIL single_vld_pulse: got %b want 0000", vld);
    end
    checks++;
    if (mif.m_valid && mif.m_ready && sb.size() > 0) begin
      e = sb.pop_front();
      if (mif.m_data !== e.d || mif.m_ch !== e.ch) begin
        errors++;
        $display("FAIL single_word: got ch=%0d data=%h want ch=%0d data=%h", mif.m_ch, mif.m_data, e.ch, e.d);
      end
    end else begin
      errors++;
      $display("FAIL single_word: got m_valid=%b want 1 after edge 4", mif.m_valid);
    end
  endtask

  task automatic test_all_channels();
    exp_t e;
    int first, last;
    do_reset();
    mif.m_ready = 1'b1;
    data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'hF;
    for (int c = 0; c < NCH; c++) push(c, 8'((c + 1) * 8'h11));
    first = -1;
    last = -1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      if (mif.m_valid && mif.m_ready) begin
        e = sb.pop_front();
        if (first < 0) first = i;
        last = i;
        checks++;
        if (mif.m_data !== e.d || mif.m_ch !== e.ch) begin
          errors++;
          $display("FAIL all_ch_word: got ch=%0d data=%h want ch=%0d data=%h", mif.m_ch, mif.m_data, e.ch, e.d);
        end
      end
      tick();
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL all_ch_timeout: got %0d words left want 0", sb.size());
    end
    checks++;
    if (last - first != 3) begin
      errors++;
      $display("FAIL all_ch_throughput: got span %0d cycles want 3", last - first);
    end
    checks++;
    if (mif.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL all_ch_drain: got m_valid=%b want 0", mif.m_valid);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    do_reset();
    mif.m_ready = 1'b0;
    req[0] = 1'b1; data[7:0] = 8'h77;
    req[2] = 1'b1; data[23:16] = 8'h5A;
    push(0, 8'h77);
    repeat (4) tick();
    checks++;
    if (mif.m_valid !== 1'b1 || mif.m_data !== 8'h77) begin
      errors++;
      $display("FAIL bp_first: got mv=%b md=%h want mv=1 md=77", mif.m_valid, mif.m_data);
    end
    req[2] = 1'b0; data[23:16] = 8'hC3;
    push(2, 8'hC3);
    repeat (6) tick();
    checks++;
    if (mif.m_data !== 8'h77 || mif.m_ch !== 2'd0 || mif.m_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: got mv=%b ch=%0d md=%h want mv=1 ch=0 md=77", mif.m_valid, mif.m_ch, mif.m_data);
    end
    checks++;
    if (ovf !== 4'b0100) begin
      errors++;
      $display("FAIL bp_ovf_set: got ovf=%b want 0100", ovf);
    end
    mif.m_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      if (mif.m_valid && mif.m_ready) begin
        e = sb.pop_front();
        checks++;
        if (mif.m_data !== e.d || mif.m_ch !== e.ch) begin
          errors++;
          $display("FAIL bp_word: got ch=%0d data=%h want ch=%0d data=%h", mif.m_ch, mif.m_data, e.ch, e.d);
        end
      end
      tick();
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL bp_timeout: got %0d words left want 0", sb.size());
    end
    ovf_clr[2] = 1'b1;
    tick();
    ovf_clr[2] = 1'b0;
    checks++;
    if (ovf !== 4'b0000) begin
      errors++;
      $display("FAIL bp_ovf_clr: got ovf=%b want 0000", ovf);
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    do_reset();
    mif.m_ready = 1'b0;
    req[1:0] = 2'b11;
    data[7:0] = 8'h10; data[15:8] = 8'h21;
    push(0, 8'h10);
    push(1, 8'h21);
    repeat (4) tick();
    req[1] = 1'b0; data[15:8] = 8'h22;
    push(1, 8'h22);
    tick();
    tick();
    mif.m_ready = 1'b1;
    for (int i = 0; i < 8 && sb.size() > 0; i++) begin
      if (mif.m_valid && mif.m_ready) begin
        e = sb.pop_front();
        checks++;
        if (mif.m_data !== e.d || mif.m_ch !== e.ch) begin
          errors++;
          $display("FAIL same_cycle_word: got ch=%0d data=%h want ch=%0d data=%h", mif.m_ch, mif.m_data, e.ch, e.d);
        end
      end
      tick();
      if (i == 0) begin
        checks++;
        if (vld[1] !== 1'b1) begin
          errors++;
          $display("FAIL same_cycle_capture: got vld1=%b want 1", vld[1]);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL same_cycle_timeout: got %0d words left want 0", sb.size());
    end
    checks++;
    if (ovf !== 4'b0000) begin
      errors++;
      $display("FAIL same_cycle_ovf: got ovf=%b want 0000", ovf);
    end
  endtask

  task automatic test_mode0();
    logic [7:0] q0[$];
    logic [7:0] ev;
    logic       hist [0:9];
    int         nvld;
    do_reset();
    nvld = 0;
    hist[0] = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      req0[3] = (k <= 5);
      data0[31:24] = (k <= 5) ? 8'(k) : 8'd5;
      hist[k] = req0[3];
      if (k >= 3 && hist[k-2]) q0.push_back(data0[31:24]);
      tick();
      checks++;
      if (k >= 3 && hist[k-2]) begin
        ev = q0.pop_front();
        if (vld0 !== 4'b1000 || data_sync0[31:24] !== ev) begin
          errors++;
          $display("FAIL mode0_capture k=%0d: got vld=%b ds3=%0d want vld=1000 ds3=%0d", k, vld0, data_sync0[31:24], ev);
        end
      end else if (vld0 !== 4'b0000) begin
        errors++;
        $display("FAIL mode0_idle k=%0d: got vld=%b want 0000", k, vld0);
      end
      if (vld0[3]) nvld++;
      checks++;
      if (mif0.m_valid !== 1'b0 || ovf0 !== '0) begin
        errors++;
        $display("FAIL mode0_merge k=%0d: got mv=%b ovf=%b want 0", k, mif0.m_valid, ovf0);
      end
    end
    checks++;
    if (nvld != 5) begin
      errors++;
      $display("FAIL mode0_vld_count: got %0d want 5", nvld);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    mif.m_ready = 1'b0;
    req = 4'b1011;
    data = {8'h04, 8'h00, 8'h02, 8'h01};
    repeat (4) tick();
    checks++;
    if (mif.m_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_setup: got m_valid=%b want 1", mif.m_valid);
    end
    #2;
    rstn = 1'b0;
    req = '0;
    #1;
    checks++;
    if ({vld, ack, ovf, data_sync, mif.m_valid, mif.m_data, mif.m_ch} !== '0) begin
      errors++;
      $display("FAIL mid_reset_async: got vld=%b ack=%b ovf=%b ds=%h mv=%b md=%h want all 0",
               vld, ack, ovf, data_sync, mif.m_valid, mif.m_data);
    end
    tick();
    tick();
    rstn = 1'b1;
    sb.delete();
    mif.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (vld !== '0 || mif.m_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_after %0d: got vld=%b mv=%b want 0", i, vld, mif.m_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_toggle();
    test_all_channels();
    test_backpressure();
    test_same_cycle();
    test_mode0();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
